// File: rtl/wb_arbiter.sv
//==============================================================================
// wb_arbiter: 4-requester writeback arbiter onto three register ports and
// one flag port. Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic         CLK,
    input  logic         N_RST,
    input  logic [3:0]   REQ_VALID,
    input  logic [3:0]   REQ_RWE,
    input  logic [11:0]  REQ_ADDR,
    input  logic [127:0] REQ_DATA,
    input  logic [3:0]   REQ_FWE,
    input  logic [19:0]  REQ_FLAGS,
    output logic [3:0]   REQ_READY,
    output logic [2:0]   WA1,
    output logic [2:0]   WA2,
    output logic [2:0]   WA3,
    output logic [31:0]  WD1,
    output logic [31:0]  WD2,
    output logic [31:0]  WD3,
    output logic         WE1,
    output logic         WE2,
    output logic         WE3,
    output logic [4:0]   WDF1,
    output logic         WEF1,
    output logic [4:0]   WDF2,
    output logic         WEF2,
    input  logic         CNT_CLR,
    output logic [15:0]  STALL_CNT
);

    logic [1:0]        ptr;
    logic [3:0]        grant;
    logic [2:0][2:0]   port_addr;
    logic [2:0][31:0]  port_data;
    logic [2:0]        port_en;
    logic [1:0]        reg_cnt;
    logic              flag_used;
    logic [4:0]        flag_data;
    logic [1:0]        last_idx;
    logic              any_grant;
    logic [1:0]        sel;
    logic              ok;
    logic [2:0]        cur_addr;
    logic              contention;

    // Walk requesters from ptr; each one sees the ports already taken this cycle.
    always_comb begin
        grant     = '0;
        port_addr = '0;
        port_data = '0;
        port_en   = '0;
        reg_cnt   = '0;
        flag_used = 1'b0;
        flag_data = '0;
        last_idx  = ptr;
        any_grant = 1'b0;
        sel       = '0;
        ok        = 1'b0;
        cur_addr  = '0;
        for (int s = 0; s < 4; s++) begin
            sel      = ptr + 2'(s);
            cur_addr = REQ_ADDR[3*sel +: 3];
            ok       = REQ_VALID[sel];
            if (REQ_RWE[sel]) begin
                if (reg_cnt == 2'd3) begin
                    ok = 1'b0;
                end
                for (int k = 0; k < 3; k++) begin
                    if (port_en[k] && (port_addr[k] == cur_addr)) begin
                        ok = 1'b0;
                    end
                end
            end
            if (REQ_FWE[sel] && flag_used) begin
                ok = 1'b0;
            end
            if (ok) begin
                grant[sel] = 1'b1;
                last_idx   = sel;
                any_grant  = 1'b1;
                if (REQ_RWE[sel]) begin
                    port_en[reg_cnt]   = 1'b1;
                    port_addr[reg_cnt] = cur_addr;
                    port_data[reg_cnt] = REQ_DATA[32*sel +: 32];
                    reg_cnt            = reg_cnt + 2'd1;
                end
                if (REQ_FWE[sel]) begin
                    flag_used = 1'b1;
                    flag_data = REQ_FLAGS[5*sel +: 5];
                end
            end
        end
    end

    assign REQ_READY  = grant & {4{N_RST}};
    assign contention = |(REQ_VALID & ~grant);
    assign WDF2       = '0;
    assign WEF2       = 1'b0;

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            WE1  <= 1'b0;
            WE2  <= 1'b0;
            WE3  <= 1'b0;
            WA1  <= '0;
            WA2  <= '0;
            WA3  <= '0;
            WD1  <= '0;
            WD2  <= '0;
            WD3  <= '0;
            WEF1 <= 1'b0;
            WDF1 <= '0;
        end else begin
            WE1  <= port_en[0];
            WE2  <= port_en[1];
            WE3  <= port_en[2];
            WA1  <= port_addr[0];
            WA2  <= port_addr[1];
            WA3  <= port_addr[2];
            WD1  <= port_data[0];
            WD2  <= port_data[1];
            WD3  <= port_data[2];
            WEF1 <= flag_used;
            WDF1 <= flag_data;
        end
    end

    generate
        if (RR_EN != 0) begin : g_rr
            always_ff @(posedge CLK or negedge N_RST) begin
                if (!N_RST) begin
                    ptr <= '0;
                end else if (any_grant) begin
                    ptr <= last_idx + 2'd1;
                end
            end
        end else begin : g_fixed
            always_ff @(posedge CLK or negedge N_RST) begin
                if (!N_RST) begin
                    ptr <= '0;
                end else begin
                    ptr <= '0;
                end
            end
        end
    endgenerate

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            STALL_CNT <= '0;
        end else if (CNT_CLR) begin
            STALL_CNT <= '0;
        end else if (contention && (STALL_CNT != 16'hFFFF)) begin
            STALL_CNT <= STALL_CNT + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//==============================================================================
// tb_wb_arbiter: scoreboard bench for wb_arbiter (round-robin and fixed).
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] cyc = 32'd0;
    always @(posedge CLK) cyc <= cyc + 32'd1;

    logic         n_rst;
    logic [3:0]   valid, rwe, fwe, ready;
    logic [11:0]  addr;
    logic [127:0] data;
    logic [19:0]  flags;
    logic         cnt_clr;
    logic [2:0]   wa1, wa2, wa3;
    logic [31:0]  wd1, wd2, wd3;
    logic         we1, we2, we3, wef1, wef2;
    logic [4:0]   wdf1, wdf2;
    logic [15:0]  stall;

    logic [3:0]   valid2, rwe2, fwe2, ready2;
    logic [11:0]  addr2;
    logic [127:0] data2;
    logic [19:0]  flags2;
    logic         cnt_clr2;
    logic [2:0]   x_wa1, x_wa2, x_wa3;
    logic [31:0]  x_wd1, x_wd2, x_wd3;
    logic         x_we1, x_we2, x_we3, x_wef1, x_wef2;
    logic [4:0]   x_wdf1, x_wdf2;
    logic [15:0]  stall2;

    wb_arbiter #(.RR_EN(1)) dut (
        .CLK(CLK), .N_RST(n_rst),
        .REQ_VALID(valid), .REQ_RWE(rwe), .REQ_ADDR(addr), .REQ_DATA(data),
        .REQ_FWE(fwe), .REQ_FLAGS(flags), .REQ_READY(ready),
        .WA1(wa1), .WA2(wa2), .WA3(wa3), .WD1(wd1), .WD2(wd2), .WD3(wd3),
        .WE1(we1), .WE2(we2), .WE3(we3), .WDF1(wdf1), .WEF1(wef1),
        .WDF2(wdf2), .WEF2(wef2), .CNT_CLR(cnt_clr), .STALL_CNT(stall)
    );

    wb_arbiter #(.RR_EN(0)) dut_fixed (
        .CLK(CLK), .N_RST(n_rst),
        .REQ_VALID(valid2), .REQ_RWE(rwe2), .REQ_ADDR(addr2), .REQ_DATA(data2),
        .REQ_FWE(fwe2), .REQ_FLAGS(flags2), .REQ_READY(ready2),
        .WA1(x_wa1), .WA2(x_wa2), .WA3(x_wa3), .WD1(x_wd1), .WD2(x_wd2), .WD3(x_wd3),
        .WE1(x_we1), .WE2(x_we2), .WE3(x_we3), .WDF1(x_wdf1), .WEF1(x_wef1),
        .WDF2(x_wdf2), .WEF2(x_wef2), .CNT_CLR(cnt_clr2), .STALL_CNT(stall2)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        we1, we2, we3;
        logic [2:0]  wa1, wa2, wa3;
        logic [31:0] wd1, wd2, wd3;
        logic        wef1;
        logic [4:0]  wdf1;
        logic        wef2;
        logic [4:0]  wdf2;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_act, mon_exp;
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    // Expected write, due on the cycle after the transfer edge that follows.
    task automatic push_wr(input logic [2:0] we, input logic [2:0] a1, input logic [2:0] a2,
                           input logic [2:0] a3, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3, input logic wef, input logic [4:0] wdf);
        wr_t e;
        e      = '0;
        e.cyc  = cyc + 32'd1;
        e.we1  = we[0]; e.we2 = we[1]; e.we3 = we[2];
        e.wa1  = a1; e.wa2 = a2; e.wa3 = a3;
        e.wd1  = d1; e.wd2 = d2; e.wd3 = d3;
        e.wef1 = wef; e.wdf1 = wdf;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (we1 | we2 | we3 | wef1 | wef2) begin
            mon_act = '{cyc, we1, we2, we3, wa1, wa2, wa3, wd1, wd2, wd3, wef1, wdf1, wef2, wdf2};
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got %h, expected no write", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act === mon_exp) pass_cnt++;
                else $display("FAIL write_ports: got %h, expected %h", mon_act, mon_exp);
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [2:0] a, input logic [31:0] d,
                           input logic fw, input logic [4:0] f);
        valid[i] = 1'b1; rwe[i] = rw; fwe[i] = fw;
        addr[3*i +: 3] = a; data[32*i +: 32] = d; flags[5*i +: 5] = f;
    endtask

    task automatic clear_req(input int i);
        valid[i] = 1'b0; rwe[i] = 1'b0; fwe[i] = 1'b0;
        addr[3*i +: 3] = '0; data[32*i +: 32] = '0; flags[5*i +: 5] = '0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) clear_req(i);
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    initial begin
        n_rst = 1'b0; cnt_clr = 1'b0; cnt_clr2 = 1'b0;
        clear_all();
        valid2 = '0; rwe2 = '0; fwe2 = '0; addr2 = '0; data2 = '0; flags2 = '0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 32'h0, 1'b1, 5'h3);
        sample();
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_we", 32'({we1, we2, we3, wef1}), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        tick(); clear_all(); n_rst = 1'b1;

        // Four register requests: only three ports.
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i + 1), 32'hD000_0000 + i, 1'b0, 5'h0);
        sample(); check("four_regs_ready", 32'(ready), 32'h7);
        push_wr(3'b111, 3'd1, 3'd2, 3'd3, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 1'b0, 5'h0);
        tick(); clear_req(0); clear_req(1); clear_req(2);
        sample(); check("four_regs_second", 32'(ready), 32'h8);
        push_wr(3'b001, 3'd4, 3'd0, 3'd0, 32'hD000_0003, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_all();
        sample(); check("stall_after_four", 32'(stall), 32'd1);

        // Address collision between req0 and req2.
        tick();
        set_req(0, 1'b1, 3'd5, 32'hAAAA_0000, 1'b0, 5'h0);
        set_req(2, 1'b1, 3'd5, 32'hBBBB_0002, 1'b0, 5'h0);
        sample(); check("collide_ready", 32'(ready), 32'h1);
        push_wr(3'b001, 3'd5, 3'd0, 3'd0, 32'hAAAA_0000, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_req(0);
        sample(); check("collide_second", 32'(ready), 32'h4);
        push_wr(3'b001, 3'd5, 3'd0, 3'd0, 32'hBBBB_0002, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_all();
        sample(); check("stall_after_collide", 32'(stall), 32'd2);

        // Portless request from req3 brings the pointer back to 0.
        tick(); set_req(3, 1'b0, 3'd0, 32'h0, 1'b0, 5'h0);
        sample(); check("portless_ready", 32'(ready), 32'h8);
        tick(); clear_all();

        // Two flag writers.
        tick();
        set_req(1, 1'b0, 3'd0, 32'h0, 1'b1, 5'h15);
        set_req(3, 1'b0, 3'd0, 32'h0, 1'b1, 5'h0A);
        sample(); check("flag_ready", 32'(ready), 32'h2);
        push_wr(3'b000, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'h15);
        tick(); clear_req(1);
        sample(); check("flag_second", 32'(ready), 32'h8);
        push_wr(3'b000, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'h0A);
        tick(); clear_all();
        sample(); check("stall_after_flag", 32'(stall), 32'd3);

        // Portless req0 plus three register writers, all in one cycle.
        tick();
        set_req(0, 1'b0, 3'd0, 32'h0, 1'b0, 5'h0);
        set_req(1, 1'b1, 3'd6, 32'hC000_0001, 1'b0, 5'h0);
        set_req(2, 1'b1, 3'd7, 32'hC000_0002, 1'b0, 5'h0);
        set_req(3, 1'b1, 3'd0, 32'hC000_0003, 1'b0, 5'h0);
        sample(); check("all_four_ready", 32'(ready), 32'hF);
        push_wr(3'b111, 3'd6, 3'd7, 3'd0, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 1'b0, 5'h0);
        tick(); clear_all();
        sample(); check("stall_after_all_four", 32'(stall), 32'd3);

        // Flag conflict blocks a combined register+flag writer.
        tick();
        set_req(0, 1'b0, 3'd0, 32'h0, 1'b1, 5'h01);
        set_req(2, 1'b1, 3'd2, 32'hE000_0002, 1'b1, 5'h1F);
        sample(); check("combo_ready", 32'(ready), 32'h1);
        push_wr(3'b000, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'h01);
        tick(); clear_req(0);
        sample(); check("combo_second", 32'(ready), 32'h4);
        push_wr(3'b001, 3'd2, 3'd0, 3'd0, 32'hE000_0002, 32'h0, 32'h0, 1'b1, 5'h1F);
        tick(); clear_all();
        sample(); check("stall_after_combo", 32'(stall), 32'd4);

        // Pointer at 3: req3 beats req0 on the same address.
        tick();
        set_req(0, 1'b1, 3'd1, 32'hF000_0000, 1'b0, 5'h0);
        set_req(3, 1'b1, 3'd1, 32'hF000_0003, 1'b0, 5'h0);
        sample(); check("rr_ready", 32'(ready), 32'h8);
        push_wr(3'b001, 3'd1, 3'd0, 3'd0, 32'hF000_0003, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_req(3);
        sample(); check("rr_second", 32'(ready), 32'h1);
        push_wr(3'b001, 3'd1, 3'd0, 3'd0, 32'hF000_0000, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_all();
        sample(); check("stall_after_rr", 32'(stall), 32'd5);

        // Reset right after a grant discards the pending write.
        tick(); set_req(1, 1'b1, 3'd3, 32'h1234_5678, 1'b0, 5'h0);
        sample(); check("pre_reset_ready", 32'(ready), 32'h2);
        tick();
        n_rst = 1'b0; clear_req(1);
        set_req(0, 1'b1, 3'd1, 32'h5555_0000, 1'b0, 5'h0);
        set_req(3, 1'b1, 3'd1, 32'h5555_0003, 1'b0, 5'h0);
        sample();
        check("midreset_ready", 32'(ready), 32'h0);
        check("midreset_we", 32'({we1, we2, we3, wef1}), 32'h0);
        check("midreset_stall", 32'(stall), 32'h0);
        tick(); n_rst = 1'b1;
        sample(); check("post_reset_ready", 32'(ready), 32'h1);
        push_wr(3'b001, 3'd1, 3'd0, 3'd0, 32'h5555_0000, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_req(0);
        sample(); check("post_reset_second", 32'(ready), 32'h8);
        push_wr(3'b001, 3'd1, 3'd0, 3'd0, 32'h5555_0003, 32'h0, 32'h0, 1'b0, 5'h0);
        tick(); clear_all();
        sample(); check("post_reset_stall", 32'(stall), 32'd1);

        // Fixed priority: req1 starves, counter saturates then clears.
        tick();
        valid2 = 4'b0011; rwe2 = 4'b0011; addr2 = '0;
        data2  = {64'h0, 32'h0000_0B0B, 32'h0000_0A0A};
        sample(); check("fixed_ready", 32'(ready2), 32'h1);
        repeat (65534) @(posedge CLK);
        sample();
        check("fixed_stall_fffe", 32'(stall2), 32'hFFFE);
        check("fixed_starve", 32'(ready2), 32'h1);
        repeat (3) @(posedge CLK);
        sample(); check("fixed_stall_sat", 32'(stall2), 32'hFFFF);
        tick(); cnt_clr2 = 1'b1;
        tick(); cnt_clr2 = 1'b0;
        sample(); check("fixed_clear", 32'(stall2), 32'h0);
        tick();
        sample(); check("fixed_recount", 32'(stall2), 32'h1);
        tick(); valid2 = '0; rwe2 = '0;

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
